// File: rtl/i2c_reg_file_ctrl_if.sv
// Byte-strobe link between the I2C slave engine (master modport) and the register-file controller (slave modport).
// Every strobe is a single-cycle pulse; i2c_data_tx and stall flow back from the controller.
interface i2c_reg_file_ctrl_if;
    logic [7:0] i2c_addr_rw;
    logic       i2c_addr_rw_valid_stb;
    logic [7:0] i2c_data_rx;
    logic       i2c_data_rx_valid_stb;
    logic [7:0] i2c_data_tx;
    logic       i2c_data_tx_loaded_stb;
    logic       i2c_data_tx_done_stb;
    logic       i2c_error_stb;
    logic       stall;

    modport master (
        output i2c_addr_rw, i2c_addr_rw_valid_stb, i2c_data_rx, i2c_data_rx_valid_stb,
        output i2c_data_tx_loaded_stb, i2c_data_tx_done_stb, i2c_error_stb,
        input  i2c_data_tx, stall
    );

    modport slave (
        input  i2c_addr_rw, i2c_addr_rw_valid_stb, i2c_data_rx, i2c_data_rx_valid_stb,
        input  i2c_data_tx_loaded_stb, i2c_data_tx_done_stb, i2c_error_stb,
        output i2c_data_tx, stall
    );
endinterface

// File: rtl/i2c_reg_file_ctrl.sv
// Pointer-addressed I2C register file: RW registers at 0..NUM_REGS-1, RO inputs at RO_BASE+k; tx byte one cycle behind ptr.
// Stall is held two cycles after each tx load while tx refreshes; I2C_REG_AUTOINC_EN enables pointer auto-increment.
module i2c_reg_file_ctrl #(
    parameter int         NUM_REGS  = 4,
    parameter int         NUM_RO    = 2,
    parameter int         RO_BASE   = 'h80,
    parameter logic [7:0] RESET_VAL = 8'h00,
    localparam int        RO_W      = (NUM_RO > 0) ? 8 * NUM_RO : 8
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_reg_file_ctrl_if.slave    bus,
    input  logic [RO_W-1:0]       ro_in_i,
    output logic [8*NUM_REGS-1:0] reg_out_o,
    output logic                  wr_stb_o,
    output logic [7:0]            wr_addr_o,
    output logic [7:0]            ptr_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_PTR, ST_WDATA, ST_RDATA} state_e;

    state_e     state_q, state_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] regs_d [NUM_REGS];
    logic       wr_stb_q, wr_stb_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] tx_q, tx_d;
    logic [1:0] stall_cnt_q, stall_cnt_d;
    logic [7:0] rd_dat;
    logic       unused_sigs;

    assign unused_sigs = ^{bus.i2c_data_tx_done_stb, bus.i2c_addr_rw[7:1]};

    // Read map; unmapped pointers return zero.
    always_comb begin
        rd_dat = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ptr_q == 8'(k)) rd_dat = regs_q[k];
        end
        for (int k = 0; k < NUM_RO; k++) begin
            if (32'(ptr_q) == 32'(RO_BASE + k)) rd_dat = ro_in_i[8*k +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        regs_d      = regs_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        tx_d        = rd_dat;
        stall_cnt_d = (stall_cnt_q != 2'd0) ? stall_cnt_q - 2'd1 : 2'd0;

        if (bus.i2c_error_stb) begin
            state_d     = ST_IDLE;
            stall_cnt_d = 2'd0;
        end else if (bus.i2c_addr_rw_valid_stb) begin
            // Repeated start lands here too; ptr is kept so a read can follow a pointer write.
            state_d = bus.i2c_addr_rw[0] ? ST_RDATA : ST_PTR;
        end else begin
            case (state_q)
                ST_PTR: begin
                    if (bus.i2c_data_rx_valid_stb) begin
                        ptr_d   = bus.i2c_data_rx;
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (bus.i2c_data_rx_valid_stb) begin
                        if (32'(ptr_q) < 32'(NUM_REGS)) begin
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (ptr_q == 8'(k)) regs_d[k] = bus.i2c_data_rx;
                            end
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                        end
`ifdef I2C_REG_AUTOINC_EN
                        ptr_d = ptr_q + 8'd1;
`endif
                    end
                end
                ST_RDATA: begin
                    if (bus.i2c_data_tx_loaded_stb) begin
                        stall_cnt_d = 2'd2;
`ifdef I2C_REG_AUTOINC_EN
                        ptr_d = ptr_q + 8'd1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 8'h00;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VAL;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= 8'h00;
            tx_q        <= RESET_VAL;
            stall_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            regs_q      <= regs_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            tx_q        <= tx_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        reg_out_o = '0;
        for (int k = 0; k < NUM_REGS; k++) reg_out_o[8*k +: 8] = regs_q[k];
    end

    assign bus.i2c_data_tx = tx_q;
    assign bus.stall       = (stall_cnt_q != 2'd0);
    assign wr_stb_o        = wr_stb_q;
    assign wr_addr_o       = wr_addr_q;
    assign ptr_o           = ptr_q;

endmodule

// File: doc/i2c_reg_file_ctrl.md
Name: i2c_reg_file_ctrl

Overview:
- Register-file controller that sits between `i2c_simple_slave` and application logic.
- Turns the slave's byte strobes into pointer-addressed register transactions: the first byte after a write address sets the pointer, later bytes write registers, and read transactions stream registers out.
- Provides NUM_REGS read/write registers and NUM_RO read-only status inputs.
- Replaces ad-hoc din/dout glue in top-levels.

Parameters:
- NUM_REGS, 4, number of 8-bit RW registers, mapped at pointer 0..NUM_REGS-1 (1..128).
- NUM_RO, 2, number of 8-bit RO inputs, mapped at RO_BASE..RO_BASE+NUM_RO-1 (0..64).
- RO_BASE, 8'h80, pointer of the first RO register; must be >= NUM_REGS.
- RESET_VAL, 8'h00, reset value loaded into every RW register.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- i2c_addr_rw  in  8  {7-bit address, R/W} from slave; bit0=1 means read.
- i2c_addr_rw_valid_stb  in  1  address byte matched and accepted.
- i2c_data_rx  in  8  received data byte.
- i2c_data_rx_valid_stb  in  1  i2c_data_rx valid, 1 cycle.
- i2c_data_tx  out  8  byte to transmit on read.
- i2c_data_tx_loaded_stb  in  1  slave latched i2c_data_tx into its shifter.
- i2c_data_tx_done_stb  in  1  tx byte finished (ACK/NACK sampled).
- i2c_error_stb  in  1  bus error / unexpected STOP.
- stall  out  1  to slave stall input; holds SCL while tx data is being refreshed.
- ro_in  in  8*NUM_RO  RO inputs; byte k is at pointer RO_BASE+k.
- reg_out  out  8*NUM_REGS  RW register contents; byte k is register k.
- wr_stb  out  1  1-cycle pulse after an RW register is written.
- wr_addr  out  8  pointer of the last write; valid with wr_stb.
- ptr  out  8  current register pointer (debug).

Behaviour:
- Reset (synchronous, from any state):
  - state=IDLE, ptr=0, every register=RESET_VAL.
  - i2c_data_tx=read value at pointer 0 (RESET_VAL).
  - stall=0, wr_stb=0, wr_addr=0.
- FSM states: IDLE, PTR, WDATA, RDATA.
- Address strobe, accepted in any state (covers repeated start):
  - bit0=0 -> PTR.
  - bit0=1 -> RDATA; ptr is unchanged, so write-pointer-then-restart-read works.
- PTR:
  - On rx stb: ptr<=i2c_data_rx, go to WDATA.
  - No register write; wr_stb stays 0.
- WDATA:
  - On rx stb with ptr<NUM_REGS: reg[ptr]<=rx, next cycle wr_stb=1 and wr_addr=ptr.
  - On rx stb with ptr>=NUM_REGS: write silently dropped, no wr_stb.
  - In both cases ptr<=ptr+1, mod 256 (8'hFF -> 8'h00).
- RDATA:
  - On tx_loaded_stb: ptr<=ptr+1 (mod 256).
  - stall=1 in the cycle after loaded_stb and the cycle after that.
  - i2c_data_tx updates to the new pointer's value; stall drops once it is stable.
  - tx_done_stb: no state change. Slave NACK-then-STOP ends the transfer; the next address strobe or error returns control.
- Read map, registered one cycle after ptr changes:
  - ptr<NUM_REGS -> reg[ptr].
  - RO_BASE<=ptr<RO_BASE+NUM_RO -> ro_in byte.
  - Otherwise -> 8'h00.
  - In IDLE/PTR/WDATA, i2c_data_tx still tracks ptr, so the first read byte is ready before any loaded_stb.
- i2c_error_stb: go to IDLE; ptr and registers are retained; stall<=0.
- Simultaneous events in one cycle:
  - Address strobe has priority over rx/loaded strobes.
  - Error has priority over everything except rst.
- RO inputs are sampled when i2c_data_tx is refreshed; they need no synchronizer inside this block (caller's responsibility).

Optional Feature:
- Macro: I2C_REG_AUTOINC_EN.
- Defined: ptr auto-increments after every WDATA byte and every tx_loaded_stb, as above.
- Undefined:
  - ptr changes only in PTR state; repeated writes overwrite the same register and repeated reads return the same register.
  - stall still pulses after loaded_stb so timing is identical.

Test Plan:
- Reset, then address 8'h84 (write), bytes 8'h01, 8'hA5, 8'h3C -> reg1=8'hA5, reg2=8'h3C, two wr_stb pulses with wr_addr=1 then 2, ptr=3.
- After the above, address 8'h84 (write) with byte 8'h01, then repeated-start address 8'h85 (read) with two tx_loaded_stb -> i2c_data_tx shows 8'hA5 then 8'h3C; stall high for 2 cycles after each loaded_stb.
- ro_in={8'h77,8'h55}, write pointer 8'h80, read 3 bytes -> tx sequence 8'h55, 8'h77, 8'h00.
- Write pointer 8'hFF, then 2 data bytes with NUM_REGS=4 -> byte to 8'hFF dropped, byte to 8'h00 written, single wr_stb with wr_addr=0.
- i2c_error_stb mid-WDATA, then rx stb with 8'hEE -> no write, state IDLE, ptr kept; rst asserted mid-RDATA -> all regs=RESET_VAL, ptr=0, stall=0 next cycle.
- Build without I2C_REG_AUTOINC_EN: pointer 2, bytes 8'h11, 8'h22 -> reg2=8'h22, reg3 unchanged, ptr=2.
